pixel_byte_serializer: RTL and testbench

- Downstream stage of the frame pixel processor: accepts processed 24-bit RGB pixels as a per-cycle strobe stream.
- Buffers pixels in a small FIFO and emits them as a byte stream (R, G, B) over a valid/ready handshake toward the host/transmit interface.
- Flags the last byte of each frame and records FIFO overflow.

---
 rtl/pixel_byte_serializer_if.sv | 26 ++
 rtl/pixel_byte_serializer.sv | 133 +++++++++++++
 tb/tb_pixel_byte_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_byte_serializer_if.sv
// Pixel-in / byte-out handshake bundle for pixel_byte_serializer.
// master drives pixels and byte_ready; slave is the serializer itself.
interface pixel_byte_serializer_if #(
   parameter int PTR_W = 4
);
   logic [23:0]    pix_in;
   logic           pix_valid_in;
   logic [7:0]     byte_out;
   logic           byte_valid;
   logic           byte_ready;
   logic           byte_last;
   logic [PTR_W:0] fifo_level;
   logic           overflow;
   logic           clear_overflow;
   logic           busy;

   modport master (
      output pix_in, pix_valid_in, byte_ready, clear_overflow,
      input  byte_out, byte_valid, byte_last, fifo_level, overflow, busy
   );

   modport slave (
      input  pix_in, pix_valid_in, byte_ready, clear_overflow,
      output byte_out, byte_valid, byte_last, fifo_level, overflow, busy
   );
endinterface

// File: rtl/pixel_byte_serializer.sv
// Buffers 24-bit pixels in a FIFO and emits them as a 3-byte valid/ready stream.
// Define PIX_SER_BGR_EN to emit B,G,R instead of R,G,B (byte_last stays on the third byte).
//
// state  | meaning
// IDLE   | no pixel held; pop FIFO head when non-empty
// SEND_R | first byte of held pixel offered
// SEND_G | second byte of held pixel offered
// SEND_B | third byte offered; on accept pop next pixel or return to IDLE
module pixel_byte_serializer #(
   parameter int FIFO_DEPTH   = 16,
   parameter int PTR_W        = 4,
   parameter int FRAME_PIXELS = 262144
) (
   input  logic                    clk,
   input  logic                    rst,
   pixel_byte_serializer_if.slave  bus
);
   localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

   typedef enum logic [1:0] {IDLE, SEND_R, SEND_G, SEND_B} state_t;

   state_t           r_state, w_next;
   logic [23:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [23:0]      r_hold;
   logic [CNT_W-1:0] r_pix_cnt;
   logic             r_last_pix;
   logic             r_overflow;

   logic             w_full, w_empty, w_push, w_pop, w_drop, w_accept;
   logic [7:0]       w_first, w_third, w_byte;

   assign w_full   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_push   = bus.pix_valid_in && !w_full;
   assign w_drop   = bus.pix_valid_in && w_full;
   assign w_accept = (r_state != IDLE) && bus.byte_ready;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.pix_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Set wins over clear when a drop coincides with clear_overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    r_overflow <= 1'b0;
      else if (w_drop)             r_overflow <= 1'b1;
      else if (bus.clear_overflow) r_overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_hold     <= '0;
         r_pix_cnt  <= '0;
         r_last_pix <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_hold     <= r_mem[r_rd_ptr];
            r_last_pix <= (r_pix_cnt == CNT_W'(FRAME_PIXELS-1));
            r_pix_cnt  <= (r_pix_cnt == CNT_W'(FRAME_PIXELS-1)) ? '0 : r_pix_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = SEND_R;
            end
         end
         SEND_R: if (w_accept) w_next = SEND_G;
         SEND_G: if (w_accept) w_next = SEND_B;
         SEND_B: begin
            if (w_accept) begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = SEND_R;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

`ifdef PIX_SER_BGR_EN
   assign w_first = r_hold[7:0];
   assign w_third = r_hold[23:16];
`else
   assign w_first = r_hold[23:16];
   assign w_third = r_hold[7:0];
`endif

   always_comb begin
      w_byte = '0;
      case (r_state)
         SEND_R:  w_byte = w_first;
         SEND_G:  w_byte = r_hold[15:8];
         SEND_B:  w_byte = w_third;
         default: w_byte = '0;
      endcase
   end

   assign bus.byte_out   = w_byte;
   assign bus.byte_valid = (r_state != IDLE);
   assign bus.byte_last  = (r_state == SEND_B) && r_last_pix;
   assign bus.fifo_level = r_count;
   assign bus.overflow   = r_overflow;
   assign bus.busy       = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_pixel_byte_serializer.sv
// Directed bench for pixel_byte_serializer: scoreboard of expected bytes fed at push time,
// checked by a negedge monitor on every accepted byte.
module tb_pixel_byte_serializer;
   localparam int FD = 16;
   localparam int PW = 4;
   localparam int FP = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pixel_byte_serializer_if #(.PTR_W(PW)) bus();

   pixel_byte_serializer #(
      .FIFO_DEPTH(FD), .PTR_W(PW), .FRAME_PIXELS(FP)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   int         errors = 0;
   int         checks = 0;
   logic [8:0] sb_q[$];
   int         last_pos[$];
   int         model_cnt = 0;
   int         byte_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_byte = '0;
   logic [8:0] mon_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pix(input logic [23:0] p, input bit accepted);
      logic lst;
      bus.pix_in       = p;
      bus.pix_valid_in = 1'b1;
      if (accepted) begin
         lst       = (model_cnt == FP-1);
         model_cnt = (model_cnt + 1) % FP;
         sb_q.push_back({1'b0, p[23:16]});
         sb_q.push_back({1'b0, p[15:8]});
         sb_q.push_back({lst,  p[7:0]});
      end
      step();
      bus.pix_valid_in = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < budget), 1);
      chk("sb_empty", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", bus.byte_valid, 1);
            chk("hold_byte", bus.byte_out, prev_byte);
         end
         if (bus.byte_valid && bus.byte_ready) begin
            byte_cnt++;
            if (bus.byte_last) last_pos.push_back(byte_cnt);
            if (sb_q.size() == 0) begin
               chk("unexpected_byte", sb_q.size(), 1);
            end else begin
               mon_exp = sb_q.pop_front();
               chk("byte", bus.byte_out, mon_exp[7:0]);
               chk("last", bus.byte_last, mon_exp[8]);
            end
         end
         stall_prev = bus.byte_valid && !bus.byte_ready;
         prev_byte  = bus.byte_out;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int maxlvl, nvalid, first, lastv, bc0;
      bit pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      bus.pix_in         = '0;
      bus.pix_valid_in   = 1'b0;
      bus.byte_ready     = 1'b1;
      bus.clear_overflow = 1'b0;

      // reset state
      #12;
      chk("rst_valid", bus.byte_valid, 0);
      chk("rst_byte", bus.byte_out, 0);
      chk("rst_last", bus.byte_last, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_busy", bus.busy, 0);
      step();
      rst = 1'b1;
      step();

      // single pixel latency and order
      drive_pix(24'h112233, 1'b1);
      chk("lat_n_valid", bus.byte_valid, 0);
      chk("lat_n_level", bus.fifo_level, 1);
      step();
      chk("lat_r_valid", bus.byte_valid, 1);
      chk("lat_r_byte", bus.byte_out, 8'h11);
      step();
      chk("lat_g_byte", bus.byte_out, 8'h22);
      step();
      chk("lat_b_byte", bus.byte_out, 8'h33);
      step();
      chk("single_done_valid", bus.byte_valid, 0);
      chk("single_done_busy", bus.busy, 0);
      chk("single_sb", sb_q.size(), 0);

      // four back-to-back pixels: 12 gapless bytes
      maxlvl = 0; nvalid = 0; first = -1; lastv = -1;
      for (int i = 0; i < 16; i++) begin
         if (i < 4) drive_pix(24'h405060 + 24'(i * 24'h010101), 1'b1);
         else       step();
         if (int'(bus.fifo_level) > maxlvl) maxlvl = int'(bus.fifo_level);
         if (bus.byte_valid) begin
            nvalid++;
            if (first < 0) first = i;
            lastv = i;
         end
      end
      chk("b2b_nvalid", nvalid, 12);
      chk("b2b_span", lastv - first + 1, 12);
      chk("b2b_lvl_peak", maxlvl, 3);
      wait_idle(50);

      // stalls with ready pattern 1,0,0,1
      bc0 = byte_cnt;
      drive_pix(24'hAABBCC, 1'b1);
      for (int i = 0; i < 12; i++) begin
         bus.byte_ready = pat[i % 4];
         step();
      end
      bus.byte_ready = 1'b1;
      wait_idle(50);
      chk("stall_bytes", byte_cnt - bc0, 3);

      // overflow: one pixel goes to the hold register, 16 fill the FIFO, 3 dropped
      bus.byte_ready = 1'b0;
      for (int i = 0; i < 20; i++) drive_pix(24'hC01020 + 24'(i), i < 17);
      chk("ovf_level", bus.fifo_level, 16);
      chk("ovf_flag", bus.overflow, 1);
      chk("ovf_hold_byte", bus.byte_out, 8'hC0);
      bc0 = byte_cnt;
      bus.byte_ready = 1'b1;
      wait_idle(200);
      chk("ovf_bytes_out", byte_cnt - bc0, 51);
      chk("ovf_sticky", bus.overflow, 1);
      bus.clear_overflow = 1'b1;
      step();
      bus.clear_overflow = 1'b0;
      chk("ovf_cleared", bus.overflow, 0);

      // frame boundary: fresh counter after reset, last on bytes 12 and 24
      rst = 1'b0;
      #1;
      sb_q.delete();
      model_cnt = 0;
      step();
      rst = 1'b1;
      last_pos.delete();
      bc0 = byte_cnt;
      for (int i = 0; i < 8; i++) drive_pix(24'h102030 + 24'(i * 24'h030201), 1'b1);
      wait_idle(100);
      chk("frame_last_count", last_pos.size(), 2);
      if (last_pos.size() >= 2) begin
         chk("frame_last_pos0", last_pos[0] - bc0, 12);
         chk("frame_last_pos1", last_pos[1] - bc0, 24);
      end

      // reset mid-pixel in SEND_G with 5 pixels queued
      bus.byte_ready = 1'b0;
      for (int i = 0; i < 6; i++) drive_pix({8'hE0 + 8'(i), 8'h70 + 8'(i), 8'h30 + 8'(i)}, 1'b1);
      chk("mid_level", bus.fifo_level, 5);
      bus.byte_ready = 1'b1;
      step();
      bus.byte_ready = 1'b0;
      chk("mid_g_valid", bus.byte_valid, 1);
      chk("mid_g_byte", bus.byte_out, 8'h70);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", bus.byte_valid, 0);
      chk("arst_level", bus.fifo_level, 0);
      chk("arst_ovf", bus.overflow, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_byte", bus.byte_out, 0);
      sb_q.delete();
      model_cnt = 0;
      step();
      rst = 1'b1;
      bus.byte_ready = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.byte_valid) nvalid++;
      end
      chk("post_rst_silent", nvalid, 0);
      drive_pix(24'h123456, 1'b1);
      wait_idle(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
